pc_gen: RTL

- Fetch-stage program counter unit: holds the current PC, drives it to instruction memory and to pc4adder, and selects next PC from the sequential value (pc4adder output), a redirect target, or hold.
- Sits directly upstream of pc4adder and consumes its result, closing the IF loop.
- Buffers a redirect that arrives while fetch is stalled so that it is applied when the stall drops and is never lost.

---
 rtl/pc_gen_pkg.sv | 14 +
 rtl/pc_gen_if.sv | 27 ++
 rtl/pc_gen.sv | 92 +++++++++
 3 files changed

// File: rtl/pc_gen_pkg.sv
// Shared CPU definitions used by the fetch-stage PC generator and its bench.
// Holds the datapath width, the reset vector and the PC sequencer state encoding.
package pc_gen_pkg;

    localparam int unsigned CPU_XLEN = 32;
    localparam logic [CPU_XLEN-1:0] CPU_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } pc_state_e;

endpackage

// File: rtl/pc_gen_if.sv
// Fetch-control bundle between the IF stage (master) and the PC generator (slave).
// Signal names keep their direction as seen from the PC generator.
interface pc_gen_if #(
    parameter int unsigned XLEN = pc_gen_pkg::CPU_XLEN
) ();

    logic            stall_i;
    logic            redirect_i;
    logic [XLEN-1:0] redirect_pc_i;
    logic [XLEN-1:0] pc4_i;
    logic [XLEN-1:0] pc_o;
    logic            pc_valid_o;
    logic            flush_o;
    logic            pend_o;
    logic            misalign_o;

    modport master (
        output stall_i, redirect_i, redirect_pc_i, pc4_i,
        input  pc_o, pc_valid_o, flush_o, pend_o, misalign_o
    );

    modport slave (
        input  stall_i, redirect_i, redirect_pc_i, pc4_i,
        output pc_o, pc_valid_o, flush_o, pend_o, misalign_o
    );

endinterface

// File: rtl/pc_gen.sv
// Fetch-stage program counter: selects sequential, redirect or held PC each cycle,
// and parks a redirect that lands during a stall until fetch can take it.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int unsigned     XLEN     = CPU_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = CPU_RESET_PC
) (
    input logic       clk,
    input logic       rst_n,
    pc_gen_if.slave   bus
);

    pc_state_e       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pend_q, pend_d;
    logic            flush_q, flush_d;
    logic            misalign_q, misalign_d;
    logic [XLEN-1:0] target;

    // A live redirect always beats the parked one, so the youngest target wins.
    assign target = bus.redirect_i ? bus.redirect_pc_i : pend_q;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no branch can infer a latch.
        state_d    = state_q;
        pc_d       = pc_q;
        pend_d     = pend_q;
        flush_d    = 1'b0;
        misalign_d = 1'b0;

        case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
            end

            ST_RUN: begin
                if (bus.redirect_i && !bus.stall_i) begin
                    pc_d       = {target[XLEN-1:2], 2'b00};
                    flush_d    = 1'b1;
                    misalign_d = |target[1:0];
                end else if (bus.redirect_i) begin
                    pend_d  = bus.redirect_pc_i;
                    state_d = ST_HOLD;
                end else if (!bus.stall_i) begin
                    pc_d = bus.pc4_i;
                end
            end

            ST_HOLD: begin
                if (bus.stall_i) begin
                    if (bus.redirect_i) begin
                        pend_d = bus.redirect_pc_i;
                    end
                end else begin
                    pc_d       = {target[XLEN-1:2], 2'b00};
                    flush_d    = 1'b1;
                    misalign_d = |target[1:0];
                    state_d    = ST_RUN;
                end
            end

            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_PC;
            pend_q     <= '0;
            flush_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            // NOTE: non-blocking updates keep every register sampling pre-edge values.
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_q     <= pend_d;
            flush_q    <= flush_d;
            misalign_q <= misalign_d;
        end
    end

    assign bus.pc_o       = pc_q;
    assign bus.pc_valid_o = (state_q != ST_BOOT);
    assign bus.pend_o     = (state_q == ST_HOLD);
    assign bus.flush_o    = flush_q;
    assign bus.misalign_o = misalign_q;

endmodule
